// File: rtl/pixel_frame_rx_pkg.sv
// Shared types and default geometry for the pixel frame receiver.
package pixel_rx_pkg;
   localparam int GS_BITS_DEF   = 8;
   localparam int IMG_DIM_DEF   = 30;
   localparam int ADDR_BITS_DEF = 10;
   localparam int NUM_PIX       = IMG_DIM_DEF * IMG_DIM_DEF;

   typedef logic [GS_BITS_DEF-1:0] pixel_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_FILL,
      W_STALL
   } wr_state_t;
endpackage

// File: rtl/pixel_frame_rx_if.sv
// Pixel stream and frame read port bundle; master drives pixels and read requests.
interface pixel_frame_rx_if import pixel_rx_pkg::*; #(
   parameter int GS_BITS   = GS_BITS_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF
);
   logic [GS_BITS-1:0]   pixel_i;
   logic                 pixel_i_valid;
   logic                 frame_busy;
   logic                 overflow_o;
   logic                 frame_valid;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [GS_BITS-1:0]   rd_data;
   logic                 frame_release;
   logic [ADDR_BITS-1:0] wr_count_o;

   modport master (
      output pixel_i, pixel_i_valid, rd_addr, frame_release,
      input  frame_busy, overflow_o, frame_valid, rd_data, wr_count_o
   );

   modport slave (
      input  pixel_i, pixel_i_valid, rd_addr, frame_release,
      output frame_busy, overflow_o, frame_valid, rd_data, wr_count_o
   );
endinterface

// File: rtl/pixel_frame_rx_frame_ram_2bank.sv
// Two-bank frame store: one write port, one registered read port with enable.
module frame_ram_2bank #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 10,
   parameter int DEPTH     = 900
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic                 wr_bank,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   input  logic                 rd_bank,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data
);
   logic [DATA_BITS-1:0] mem0 [DEPTH];
   logic [DATA_BITS-1:0] mem1 [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         if (wr_bank) mem1[wr_addr] <= wr_data;
         else         mem0[wr_addr] <= wr_data;
      end
   end

   // Disabled reads return zero so the output never shows uninitialised storage.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
      else            rd_data <= '0;
   end
endmodule

// File: rtl/pixel_frame_rx.sv
// Ping-pong frame assembler for the CNN input; PIXEL_FRAME_RX_INVERT_EN stores ~pixel_i.
module pixel_frame_rx import pixel_rx_pkg::*; #(
   parameter int GS_BITS   = GS_BITS_DEF,
   parameter int IMG_DIM   = IMG_DIM_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   pixel_frame_rx_if.slave  bus
);
   localparam int NPIX = IMG_DIM * IMG_DIM;
   localparam logic [ADDR_BITS-1:0] LAST   = ADDR_BITS'(NPIX - 1);
   localparam logic [ADDR_BITS:0]   NPIX_W = (ADDR_BITS + 1)'(NPIX);

   wr_state_t            state;
   logic [ADDR_BITS-1:0] count;
   logic                 wr_bank, rd_bank;
   logic [1:0]           bank_full, full_nxt;
   logic                 wr_bank_nxt, rd_bank_nxt;
   logic                 accept, frame_done, release_ok, rd_en;
   logic                 frame_busy_q, overflow_q, frame_valid_q;
   logic [GS_BITS-1:0]   wr_data;

`ifdef PIXEL_FRAME_RX_INVERT_EN
   assign wr_data = ~bus.pixel_i;
`else
   assign wr_data = bus.pixel_i;
`endif

   always_comb begin
      accept      = bus.pixel_i_valid && !frame_busy_q;
      frame_done  = accept && (count == LAST);
      release_ok  = bus.frame_release && bank_full[rd_bank];
      full_nxt    = bank_full;
      if (frame_done) full_nxt[wr_bank] = 1'b1;
      if (release_ok) full_nxt[rd_bank] = 1'b0;
      wr_bank_nxt = wr_bank ^ frame_done;
      rd_bank_nxt = rd_bank ^ release_ok;
      rd_en       = bank_full[rd_bank] && ({1'b0, bus.rd_addr} < NPIX_W);
   end

   // Busy/valid are registered from next-state values so they track bank_full without lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= W_IDLE;
         count         <= '0;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         bank_full     <= '0;
         frame_busy_q  <= 1'b0;
         overflow_q    <= 1'b0;
         frame_valid_q <= 1'b0;
      end else begin
         wr_bank       <= wr_bank_nxt;
         rd_bank       <= rd_bank_nxt;
         bank_full     <= full_nxt;
         frame_busy_q  <= full_nxt[wr_bank_nxt];
         frame_valid_q <= full_nxt[rd_bank_nxt];
         if (bus.pixel_i_valid && frame_busy_q) overflow_q <= 1'b1;
         if (frame_done) begin
            count <= '0;
            state <= full_nxt[wr_bank_nxt] ? W_STALL : W_IDLE;
         end else if (accept) begin
            count <= count + 1'b1;
            state <= W_FILL;
         end else if (state == W_STALL && !bank_full[wr_bank]) begin
            state <= W_IDLE;
         end
      end
   end

   frame_ram_2bank #(
      .DATA_BITS (GS_BITS),
      .ADDR_BITS (ADDR_BITS),
      .DEPTH     (NPIX)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (accept),
      .wr_bank (wr_bank),
      .wr_addr (count),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_bank (rd_bank),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

   assign bus.frame_busy  = frame_busy_q;
   assign bus.overflow_o  = overflow_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.wr_count_o  = count;
endmodule

// File: tb/tb_pixel_frame_rx.sv
// Self-checking bench: frame-FIFO reference model plus directed literal checks.
module tb_pixel_frame_rx;
   import pixel_rx_pkg::*;

   localparam int NP = 900;
`ifdef PIXEL_FRAME_RX_INVERT_EN
   localparam logic [7:0] INV = 8'hFF;
`else
   localparam logic [7:0] INV = 8'h00;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pixel_frame_rx_if #(.GS_BITS(8), .ADDR_BITS(10)) bus ();

   pixel_frame_rx #(.GS_BITS(8), .IMG_DIM(30), .ADDR_BITS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: up to two complete frames held oldest-first, plus a partial frame.
   logic [7:0] fr   [2][NP];
   logic [7:0] pbuf [NP];
   int         n = 0, h = 0, pcount = 0;
   bit         ovf = 0, rd_chk = 0, started = 0;
   logic [7:0] exp_rd = 8'h00;

   always @(posedge clk) begin
      int slot;
      int a;
      bit pushed;
      started = 1;
      if (rst) begin
         n = 0; h = 0; pcount = 0; ovf = 0; rd_chk = 0; exp_rd = 8'h00;
      end else begin
         a      = int'(bus.rd_addr);
         rd_chk = (n > 0);
         exp_rd = (a < NP) ? fr[h][a] : 8'h00;
         if (bus.pixel_i_valid && n == 2) ovf = 1;
         slot   = (h + n) % 2;
         pushed = 0;
         if (bus.pixel_i_valid && n != 2) begin
            pbuf[pcount] = bus.pixel_i ^ INV;
            pcount++;
            if (pcount == NP) begin
               for (int i = 0; i < NP; i++) fr[slot][i] = pbuf[i];
               pcount = 0;
               pushed = 1;
            end
         end
         if (bus.frame_release && n > 0) begin
            h = 1 - h;
            n--;
         end
         if (pushed) n++;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("frame_busy", int'(bus.frame_busy), int'(n == 2));
         check("frame_valid", int'(bus.frame_valid), int'(n > 0));
         check("overflow_o", int'(bus.overflow_o), int'(ovf));
         check("wr_count_o", int'(bus.wr_count_o), pcount);
         if (rd_chk) check("rd_data", int'(bus.rd_data), int'(exp_rd));
      end
   end

   // Drive one cycle of inputs, then wait until the resulting outputs are settled.
   task automatic step(input logic v, input logic [7:0] p, input logic r, input int a);
      bus.pixel_i_valid = v;
      bus.pixel_i       = p;
      bus.frame_release = r;
      bus.rd_addr       = 10'(a);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      rst = 1'b0;
   endtask

   task automatic send_const(input int cnt, input logic [7:0] val);
      for (int i = 0; i < cnt; i++) step(1, val, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int k;
      logic [7:0] pv;
      rst = 1'b1;
      bus.pixel_i_valid = 1'b0;
      bus.pixel_i       = 8'h00;
      bus.frame_release = 1'b0;
      bus.rd_addr       = '0;
      @(negedge clk);
      do_reset();
      check("rst_busy", int'(bus.frame_busy), 0);
      check("rst_ovf", int'(bus.overflow_o), 0);
      check("rst_valid", int'(bus.frame_valid), 0);
      check("rst_rd_data", int'(bus.rd_data), 0);
      check("rst_wr_count", int'(bus.wr_count_o), 0);

      // Ramp frame: value = address[7:0]
      for (int i = 0; i < NP; i++) begin
         if (i == NP - 1) check("valid_before_last", int'(bus.frame_valid), 0);
         pv = 8'(i);
         step(1, pv, 0, 0);
      end
      check("valid_latency", int'(bus.frame_valid), 1);
      step(0, 8'h00, 0, 0);
      check("ramp_rd0", int'(bus.rd_data), int'(8'h00 ^ INV));
      step(0, 8'h00, 0, 1);
      check("ramp_rd1", int'(bus.rd_data), int'(8'h01 ^ INV));
      step(0, 8'h00, 0, 899);
      check("ramp_rd899", int'(bus.rd_data), int'(8'h83 ^ INV));
      check("ramp_ovf", int'(bus.overflow_o), 0);

      // Two frames back to back, then overflow while busy
      do_reset();
      send_const(NP, 8'h11);
      send_const(NP, 8'h22);
      check("busy_after_b", int'(bus.frame_busy), 1);
      send_const(50, 8'h33);
      check("ovf_set", int'(bus.overflow_o), 1);
      check("count_held", int'(bus.wr_count_o), 0);
      step(0, 8'h00, 0, 5);
      check("read_a", int'(bus.rd_data), int'(8'h11 ^ INV));
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 7);
      check("read_b", int'(bus.rd_data), int'(8'h22 ^ INV));
      k = 0;
      while (bus.frame_busy && k < 2) begin
         step(0, 8'h00, 0, 0);
         k++;
      end
      check("busy_drop", int'(bus.frame_busy), 0);
      check("ovf_sticky", int'(bus.overflow_o), 1);
      step(0, 8'h00, 1, 0);
      check("valid_after_2rel", int'(bus.frame_valid), 0);

      // Release with no frame is ignored
      step(0, 8'h00, 1, 0);
      check("idle_rel_valid", int'(bus.frame_valid), 0);
      check("idle_rel_busy", int'(bus.frame_busy), 0);
      for (int i = 0; i < NP; i++) begin
         pv = 8'(i * 3);
         step(1, pv, 0, 0);
      end
      step(0, 8'h00, 0, 10);
      check("after_idle_rel", int'(bus.rd_data), int'(8'h1E ^ INV));
      step(0, 8'h00, 1, 0);

      // Reset mid-frame discards partial data
      do_reset();
      send_const(450, 8'h77);
      do_reset();
      seen = 0;
      for (int i = 0; i < NP; i++) begin
         seen |= bus.frame_valid;
         step(1, 8'h5A, 0, 0);
      end
      check("no_early_valid", int'(seen), 0);
      check("fresh_valid", int'(bus.frame_valid), 1);
      for (int i = 0; i < 6; i++) begin
         step(0, 8'h00, 0, (i == 5) ? 899 : int'($urandom_range(0, NP - 1)));
         check("fresh_rd", int'(bus.rd_data), int'(8'h5A ^ INV));
      end
      step(0, 8'h00, 0, 900);
      check("rd_out_of_range", int'(bus.rd_data), 0);
      step(0, 8'h00, 0, 1023);
      check("rd_out_of_range_max", int'(bus.rd_data), 0);

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         rst = (i == 3000);
         pv = 8'($urandom);
         step(($urandom % 4) != 0, pv, ($urandom % 300) == 0,
              (($urandom % 8) == 0) ? int'($urandom_range(NP, 1023))
                                    : int'($urandom_range(0, NP - 1)));
      end
      rst = 1'b0;
      step(0, 8'h00, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
